// File: rtl/dp_framer_pkg.sv
// dp_framer_pkg: DisplayPort framing symbol constants and lane helpers.
package dp_framer_pkg;
  localparam logic [7:0] SYM_BS   = 8'hBC;
  localparam logic [7:0] SYM_BE   = 8'hFB;
  localparam logic [7:0] SYM_SR   = 8'h1C;
  localparam logic [7:0] SYM_MAUD = 8'h00;
  localparam int VBID_VBLANK = 0;
  localparam int SR_W = 9;
  typedef struct packed {
    logic [3:0]  isk;
    logic [31:0] dat;
  } sym_t;
  function automatic sym_t lanes(input logic [7:0] s, input logic k);
    return '{isk: {4{k}}, dat: {4{s}}};
  endfunction
endpackage

// File: rtl/dp_framer_timing.sv
// dp_framer_timing: line/frame counters and slot decode for the framer.
module dp_framer_timing #(
  parameter int HACT   = 480,
  parameter int VACT   = 480,
  parameter int HTOTAL = 525,
  parameter int VTOTAL = 500,
  parameter int HW     = $clog2(HTOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [HW-1:0] hcnt,
  output logic          vblank,
  output logic          be_slot,
  output logic          data_slot,
  output logic          frame_start
);
  localparam int VW = $clog2(VTOTAL);
  logic [VW-1:0] vcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= VW'(VACT);
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= VW'(VACT);
    end else if (hcnt == HW'(HTOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VW'(VTOTAL - 1)) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  assign vblank      = vcnt >= VW'(VACT);
  assign be_slot     = !vblank && hcnt == HW'(HTOTAL - HACT - 1);
  assign data_slot   = !vblank && hcnt >= HW'(HTOTAL - HACT);
  assign frame_start = hcnt == '0 && vcnt == VW'(VACT);
endmodule

// File: rtl/dp_framer.sv
// dp_framer: DisplayPort main-link framer (BS/VB-ID/Mvid/Maud/BE + pixel data).
// Define DP_FRAMER_SR_EN to replace every 512th BS with SR.
module dp_framer
  import dp_framer_pkg::*;
#(
  parameter int         HACT   = 480,
  parameter int         VACT   = 480,
  parameter int         HTOTAL = 525,
  parameter int         VTOTAL = 500,
  parameter logic [7:0] MVID   = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] indat,
  output logic        consume,
  output logic        restart,
  output logic [31:0] dat,
  output logic [3:0]  isk
);
  localparam int HW = $clog2(HTOTAL);
  logic [HW-1:0] hcnt;
  logic          vblank, be_slot, data_slot, frame_start;
  logic [7:0]    bs_sym, vbid;
  sym_t          nxt;

  dp_framer_timing #(
    .HACT(HACT), .VACT(VACT), .HTOTAL(HTOTAL), .VTOTAL(VTOTAL), .HW(HW)
  ) u_timing (
    .clk(clk), .rst_n(rst_n), .en(en), .hcnt(hcnt), .vblank(vblank),
    .be_slot(be_slot), .data_slot(data_slot), .frame_start(frame_start)
  );

  // rst_n gating keeps the strobes low while the counters sit at their reset state
  assign consume = rst_n && en && data_slot;
  assign restart = rst_n && en && frame_start;

`ifdef DP_FRAMER_SR_EN
  logic [SR_W-1:0] sr_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_cnt <= '0;
    else if (!en) sr_cnt <= '0;
    else if (hcnt == '0) sr_cnt <= sr_cnt + 1'b1;
  assign bs_sym = (sr_cnt == '0) ? SYM_SR : SYM_BS;
`else
  assign bs_sym = SYM_BS;
`endif

  always_comb begin
    vbid = '0;
    vbid[VBID_VBLANK] = vblank;
    nxt = !en                ? '0 :
          hcnt == HW'(0)     ? lanes(bs_sym, 1'b1) :
          hcnt == HW'(1)     ? lanes(vbid, 1'b0) :
          hcnt == HW'(2)     ? lanes(MVID, 1'b0) :
          hcnt == HW'(3)     ? lanes(SYM_MAUD, 1'b0) :
          be_slot            ? lanes(SYM_BE, 1'b1) :
          data_slot          ? '{isk: 4'h0, dat: indat} : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dat <= '0;
      isk <= '0;
    end else begin
      dat <= nxt.dat;
      isk <= nxt.isk;
    end
endmodule
